// File: rtl/zion_riscv_isa_lib_add_sub_pipe.sv
// Pipelined RISC-V add/sub/compare unit (ADD/SUB/ADDW/SUBW/SLT/SLTU) with valid/ready flow
// control, flush and an in-flight counter. All arithmetic happens ahead of stage 0.
module zion_riscv_isa_lib_add_sub_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [2:0]       i_op,
    input  logic [XLEN-1:0]  i_s1,
    input  logic [XLEN-1:0]  i_s2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [XLEN-1:0]  o_rslt,
    output logic             o_lt,
    output logic             o_eq,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal,
    output logic [2:0]       o_inflight
);

    if (XLEN != 32 && XLEN != 64) begin : gBadXlen
        $error("zion_riscv_isa_lib_add_sub_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : gBadStages
        $error("zion_riscv_isa_lib_add_sub_pipe: STAGES must be 1..4");
    end

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAddW = 3'b010,
        OpSubW = 3'b011,
        OpSlt  = 3'b100,
        OpSltu = 3'b101
    } opE;

    typedef struct packed {
        logic [XLEN-1:0]  rslt;
        logic             lt;
        logic             eq;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } payloadT;

    logic [XLEN:0]   diff;
    logic [XLEN-1:0] sum;
    logic [31:0]     sumW;
    logic [31:0]     wRes;
    logic            signedLt;
    logic            unsignedLt;
    logic            opEq;
    payloadT         newP;

    // One XLEN+1 wide subtract feeds SUB, the W-form low half and both less-than flavours.
    assign diff       = {1'b0, i_s1} + {1'b0, ~i_s2} + {{XLEN{1'b0}}, 1'b1};
    assign sum        = i_s1 + i_s2;
    assign sumW       = i_s1[31:0] + i_s2[31:0];
    assign wRes       = i_op[0] ? diff[31:0] : sumW;
    assign signedLt   = (i_s1[XLEN-1] ^ i_s2[XLEN-1]) ? i_s1[XLEN-1] : diff[XLEN-1];
    assign unsignedLt = ~diff[XLEN];
    assign opEq       = (i_s1 == i_s2);

    always_comb begin
        newP     = '0;
        newP.tag = i_tag;
        case (i_op)
            OpAdd: newP.rslt = sum;
            OpSub: begin
                newP.rslt = diff[XLEN-1:0];
                newP.lt   = signedLt;
                newP.eq   = opEq;
            end
            OpAddW, OpSubW: begin
                if (XLEN == 32) begin
                    newP.illegal = 1'b1;
                end else begin
                    newP.rslt = XLEN'($signed(wRes));
                    if (i_op[0]) begin
                        newP.lt = signedLt;
                        newP.eq = opEq;
                    end
                end
            end
            OpSlt: begin
                newP.rslt = {{(XLEN-1){1'b0}}, signedLt};
                newP.lt   = signedLt;
                newP.eq   = opEq;
            end
            OpSltu: begin
                newP.rslt = {{(XLEN-1){1'b0}}, unsignedLt};
                newP.lt   = unsignedLt;
                newP.eq   = opEq;
            end
            default: newP.illegal = 1'b1;
        endcase
    end

    logic [STAGES-1:0] vldQ;
    logic [STAGES-1:0] vldD;
    logic [STAGES-1:0] vldIn;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    payloadT           dataQ   [STAGES];
    payloadT           stageIn [STAGES];
    logic [2:0]        inflightQ;
    logic [2:0]        inflightD;

    // Advance ripples back from the output: a stage moves if empty or its successor moves.
    always_comb begin
        adv            = '0;
        adv[STAGES-1]  = !vldQ[STAGES-1] | i_rdy;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k] = !vldQ[k] | adv[k+1];
        end
    end

    always_comb begin
        vldIn[0]   = i_vld;
        stageIn[0] = newP;
        for (int k = 1; k < int'(STAGES); k++) begin
            vldIn[k]   = vldQ[k-1];
            stageIn[k] = dataQ[k-1];
        end
    end

    // Flush only clears valid bits; data registers are left untouched.
    always_comb begin
        vldD      = '0;
        load      = '0;
        inflightD = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            vldD[k] = i_flush ? 1'b0 : (adv[k] ? vldIn[k] : vldQ[k]);
            load[k] = adv[k] & vldIn[k] & !i_flush;
            if (vldD[k]) begin
                inflightD = inflightD + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vldQ      <= '0;
            inflightQ <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                dataQ[k] <= '0;
            end
        end else begin
            vldQ      <= vldD;
            inflightQ <= inflightD;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    dataQ[k] <= stageIn[k];
                end
            end
        end
    end

    assign o_rdy      = adv[0];
    assign o_vld      = vldQ[STAGES-1];
    assign o_rslt     = dataQ[STAGES-1].rslt;
    assign o_lt       = dataQ[STAGES-1].lt;
    assign o_eq       = dataQ[STAGES-1].eq;
    assign o_tag      = dataQ[STAGES-1].tag;
    assign o_illegal  = dataQ[STAGES-1].illegal;
    assign o_inflight = inflightQ;

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_pipe.sv
// Bench for the add/sub pipe: a 32-bit/2-stage and a 64-bit/3-stage instance share stimulus;
// directed scenarios plus randomized traffic scored against a value-level reference model.
module tb_zion_riscv_isa_lib_add_sub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, vld = 1'b0, rdy = 1'b1;
    logic [2:0]  op = 3'd0;
    logic [63:0] s1 = '0, s2 = '0;
    logic [3:0]  tag = '0;

    logic        rdy32, vld32, lt32, eq32, ill32;
    logic [31:0] rslt32;
    logic [3:0]  tag32;
    logic [2:0]  infl32;
    logic        rdy64, vld64, lt64, eq64, ill64;
    logic [63:0] rslt64;
    logic [3:0]  tag64;
    logic [2:0]  infl64;

    zion_riscv_isa_lib_add_sub_pipe #(.XLEN(32), .STAGES(2), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_vld(vld), .o_rdy(rdy32), .i_op(op),
        .i_s1(s1[31:0]), .i_s2(s2[31:0]), .i_tag(tag), .o_vld(vld32), .i_rdy(rdy),
        .o_rslt(rslt32), .o_lt(lt32), .o_eq(eq32), .o_tag(tag32), .o_illegal(ill32),
        .o_inflight(infl32)
    );

    zion_riscv_isa_lib_add_sub_pipe #(.XLEN(64), .STAGES(3), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_vld(vld), .o_rdy(rdy64), .i_op(op),
        .i_s1(s1), .i_s2(s2), .i_tag(tag), .o_vld(vld64), .i_rdy(rdy),
        .o_rslt(rslt64), .o_lt(lt64), .o_eq(eq64), .o_tag(tag64), .o_illegal(ill64),
        .o_inflight(infl64)
    );

    typedef struct packed {
        logic [63:0] rslt;
        logic        lt;
        logic        eq;
        logic        ill;
        logic [3:0]  tag;
    } rec_t;

    int cmpCount = 0;
    int failCount = 0;

    // Value-level reference: plain integer arithmetic and relational operators.
    function automatic rec_t refModel(input int xl, input logic [2:0] rop,
                                      input logic [63:0] a0, input logic [63:0] b0,
                                      input logic [3:0] rtag);
        rec_t r;
        logic [63:0] a, b, mask;
        logic [31:0] w;
        logic sLt, uLt;
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
        a = a0 & mask;
        b = b0 & mask;
        if (xl == 32) sLt = $signed(a[31:0]) < $signed(b[31:0]);
        else          sLt = $signed(a) < $signed(b);
        uLt = a < b;
        r = '0;
        r.tag = rtag;
        case (rop)
            3'd0: r.rslt = (a + b) & mask;
            3'd1: begin r.rslt = (a - b) & mask; r.lt = sLt; r.eq = (a == b); end
            3'd2, 3'd3: begin
                if (xl == 32) begin
                    r.ill = 1'b1;
                end else begin
                    w = (rop == 3'd2) ? (a[31:0] + b[31:0]) : (a[31:0] - b[31:0]);
                    r.rslt = {{32{w[31]}}, w};
                    if (rop == 3'd3) begin r.lt = sLt; r.eq = (a == b); end
                end
            end
            3'd4: begin r.rslt = {63'd0, sLt}; r.lt = sLt; r.eq = (a == b); end
            3'd5: begin r.rslt = {63'd0, uLt}; r.lt = uLt; r.eq = (a == b); end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    rec_t cur32, cur64, hold32, hold64;
    assign cur32 = {32'd0, rslt32, lt32, eq32, ill32, tag32};
    assign cur64 = {rslt64, lt64, eq64, ill64, tag64};

    rec_t expQ32[$], pe32[$], po32[$], stA32[$], stB32[$];
    rec_t expQ64[$], pe64[$], po64[$], stA64[$], stB64[$];
    int   unexp32 = 0, unexp64 = 0;
    logic stall32 = 1'b0, stall64 = 1'b0;

    // Monitors run mid-cycle, where inputs and outputs are stable for the coming edge.
    always @(negedge clk) begin
        if (stall32) begin stA32.push_back(hold32); stB32.push_back(cur32); end
        stall32 <= vld32 && !rdy && !rst;
        hold32  <= cur32;
        if (!rst && vld32 && rdy) begin
            if (expQ32.size() > 0) begin
                pe32.push_back(expQ32.pop_front());
                po32.push_back(cur32);
            end else unexp32 <= unexp32 + 1;
        end
        if (rst || flush) expQ32.delete();
        else if (vld && rdy32) expQ32.push_back(refModel(32, op, s1, s2, tag));
    end

    always @(negedge clk) begin
        if (stall64) begin stA64.push_back(hold64); stB64.push_back(cur64); end
        stall64 <= vld64 && !rdy && !rst;
        hold64  <= cur64;
        if (!rst && vld64 && rdy) begin
            if (expQ64.size() > 0) begin
                pe64.push_back(expQ64.pop_front());
                po64.push_back(cur64);
            end else unexp64 <= unexp64 + 1;
        end
        if (rst || flush) expQ64.delete();
        else if (vld && rdy64) expQ64.push_back(refModel(64, op, s1, s2, tag));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b0; flush = 1'b0; rdy = 1'b1;
        repeat (3) tick();
        cmpCount++;
        if ({vld32, rslt32, lt32, eq32, tag32, ill32, infl32} !== '0) begin
            failCount++;
            $display("FAIL reset_out32: got %h want 0", {vld32, rslt32, lt32, eq32, tag32, ill32, infl32});
        end
        cmpCount++;
        if ({vld64, rslt64, lt64, eq64, tag64, ill64, infl64} !== '0) begin
            failCount++;
            $display("FAIL reset_out64: got %h want 0", {vld64, rslt64, lt64, eq64, tag64, ill64, infl64});
        end
        rst = 1'b0;
        #1;
        cmpCount++;
        if ({rdy32, rdy64} !== 2'b11) begin
            failCount++; $display("FAIL reset_rdy: got %b want 11", {rdy32, rdy64});
        end
    endtask

    task automatic test_add_overflow();
        tick(); vld = 1'b1; op = 3'd0; s1 = 64'h7FFF_FFFF; s2 = 64'd1; tag = 4'd3; rdy = 1'b1;
        tick(); vld = 1'b0;
        cmpCount++;
        if (vld32 !== 1'b0) begin failCount++; $display("FAIL add_early32: got %b want 0", vld32); end
        tick();
        cmpCount++;
        if ({vld32, rslt32, tag32, ill32} !== {1'b1, 32'h8000_0000, 4'd3, 1'b0}) begin
            failCount++;
            $display("FAIL add_ovf32: got %h want %h", {vld32, rslt32, tag32, ill32},
                     {1'b1, 32'h8000_0000, 4'd3, 1'b0});
        end
        cmpCount++;
        if (vld64 !== 1'b0) begin failCount++; $display("FAIL add_early64: got %b want 0", vld64); end
        tick();
        cmpCount++;
        if ({vld64, rslt64, tag64} !== {1'b1, 64'h8000_0000, 4'd3}) begin
            failCount++;
            $display("FAIL add_ovf64: got %h want %h", {vld64, rslt64, tag64}, {1'b1, 64'h8000_0000, 4'd3});
        end
    endtask

    task automatic test_compare();
        logic [2:0]  tOp [3];
        logic [63:0] tA [3];
        logic [63:0] tB [3];
        logic [33:0] tExp [3];
        tOp = '{3'd4, 3'd5, 3'd1};
        tA  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd5};
        tB  = '{64'd1, 64'd1, 64'd5};
        tExp = '{{32'd1, 1'b1, 1'b0}, {32'd0, 1'b0, 1'b0}, {32'd0, 1'b0, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            tick(); vld = 1'b1; op = tOp[i]; s1 = tA[i]; s2 = tB[i]; tag = 4'(i + 8);
            tick(); vld = 1'b0;
            tick();
            cmpCount++;
            if ({vld32, rslt32, lt32, eq32} !== {1'b1, tExp[i]}) begin
                failCount++;
                $display("FAIL compare32[%0d]: got %h want %h", i, {vld32, rslt32, lt32, eq32},
                         {1'b1, tExp[i]});
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_addw();
        tick(); vld = 1'b1; op = 3'd2; s1 = 64'h7FFF_FFFF; s2 = 64'd1; tag = 4'd7;
        tick(); vld = 1'b0;
        tick();
        cmpCount++;
        if ({vld32, ill32, rslt32, lt32, eq32} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
            failCount++;
            $display("FAIL addw_illegal32: got %h want %h", {vld32, ill32, rslt32, lt32, eq32},
                     {1'b1, 1'b1, 32'd0, 1'b0, 1'b0});
        end
        tick();
        cmpCount++;
        if ({vld64, ill64, rslt64} !== {1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000}) begin
            failCount++;
            $display("FAIL addw64: got %h want %h", {vld64, ill64, rslt64},
                     {1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000});
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] got[$];
        int firstT = -1, lastT = -1, rdyLow = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (t < 6) begin vld = 1'b1; op = 3'd0; s1 = 64'(t); s2 = 64'd100; tag = 4'(t); end
            else vld = 1'b0;
            #1;
            if (t < 6 && !rdy32) rdyLow++;
            if (vld32) begin
                got.push_back(tag32);
                if (firstT < 0) firstT = t;
                lastT = t;
            end
        end
        cmpCount++;
        if (rdyLow != 0) begin failCount++; $display("FAIL b2b_rdy: got %0d low cycles want 0", rdyLow); end
        cmpCount++;
        if (firstT != 2 || lastT != 7 || got.size() != 6) begin
            failCount++;
            $display("FAIL b2b_timing: got first %0d last %0d n %0d want 2 7 6", firstT, lastT, got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            cmpCount++;
            if (got[i] !== 4'(i)) begin
                failCount++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, got[i], i);
            end
        end
    endtask

    task automatic test_stall();
        int nextTag = 0, extra = 0;
        logic [3:0] got[$];
        rec_t snap;
        snap = '0;
        for (int c = 0; c < 5; c++) begin
            tick(); rdy = 1'b0; vld = 1'b1; op = 3'd0; s1 = 64'(nextTag); s2 = 64'd0; tag = 4'(nextTag);
            #1;
            if (c == 3) begin
                snap = cur64;
                cmpCount++;
                if ({rdy64, infl64, vld64, tag64} !== {1'b0, 3'd3, 1'b1, 4'd0}) begin
                    failCount++;
                    $display("FAIL stall_full64: got %h want %h", {rdy64, infl64, vld64, tag64},
                             {1'b0, 3'd3, 1'b1, 4'd0});
                end
            end
            if (c == 4) begin
                cmpCount++;
                if (cur64 !== snap) begin
                    failCount++; $display("FAIL stall_hold64: got %h want %h", cur64, snap);
                end
            end
            if (rdy64) nextTag++;
        end
        cmpCount++;
        if (nextTag != 3) begin failCount++; $display("FAIL stall_accepts: got %0d want 3", nextTag); end
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            tick(); rdy = 1'b1; vld = (nextTag < 4); s1 = 64'(nextTag); tag = 4'(nextTag);
            #1;
            if (vld && rdy64) nextTag++;
            if (vld64) got.push_back(tag64);
        end
        vld = 1'b0;
        repeat (4) begin tick(); if (vld64) extra++; end
        cmpCount++;
        if (got.size() != 4 || extra != 0) begin
            failCount++; $display("FAIL stall_drain: got %0d outs +%0d extra want 4 +0", got.size(), extra);
        end
        for (int i = 0; i < got.size(); i++) begin
            cmpCount++;
            if (got[i] !== 4'(i)) begin
                failCount++; $display("FAIL stall_order[%0d]: got %0d want %0d", i, got[i], i);
            end
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        tick(); vld = 1'b1; op = 3'd1; s1 = 64'd9; s2 = 64'd4; tag = 4'd1; rdy = 1'b1;
        tick(); tag = 4'd2;
        tick();
        cmpCount++;
        if (infl32 !== 3'd2) begin failCount++; $display("FAIL flush_pre32: got %0d want 2", infl32); end
        flush = 1'b1; vld = 1'b1; tag = 4'hE;
        tick(); flush = 1'b0; vld = 1'b0;
        cmpCount++;
        if ({infl32, vld32, infl64, vld64} !== '0) begin
            failCount++;
            $display("FAIL flush_clear: got %h want 0", {infl32, vld32, infl64, vld64});
        end
        repeat (6) begin tick(); if (vld32 || vld64) seen++; end
        cmpCount++;
        if (seen != 0) begin failCount++; $display("FAIL flush_ghost: got %0d outputs want 0", seen); end
    endtask

    task automatic test_reset_mid();
        tick(); vld = 1'b1; op = 3'd0; s1 = 64'd40; s2 = 64'd2; tag = 4'd9; rdy = 1'b1;
        tick(); tag = 4'd10;
        tick(); rst = 1'b1; vld = 1'b0;
        tick();
        cmpCount++;
        if ({vld32, rslt32, lt32, eq32, tag32, ill32, infl32,
             vld64, rslt64, lt64, eq64, tag64, ill64, infl64} !== '0) begin
            failCount++;
            $display("FAIL rstmid_out: got %h/%h want 0", {vld32, rslt32, tag32, infl32},
                     {vld64, rslt64, tag64, infl64});
        end
        rst = 1'b0; vld = 1'b1; op = 3'd0; s1 = 64'd2; s2 = 64'd3; tag = 4'd5;
        #1;
        cmpCount++;
        if ({rdy32, rdy64} !== 2'b11) begin
            failCount++; $display("FAIL rstmid_rdy: got %b want 11", {rdy32, rdy64});
        end
        tick(); vld = 1'b0;
        tick();
        cmpCount++;
        if ({vld32, rslt32, tag32} !== {1'b1, 32'd5, 4'd5}) begin
            failCount++;
            $display("FAIL rstmid_add32: got %h want %h", {vld32, rslt32, tag32}, {1'b1, 32'd5, 4'd5});
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 99) < 3);
            vld   = ($urandom_range(0, 3) != 0);
            op    = 3'($urandom_range(0, 7));
            s1    = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       s2 = s1;
                1:       s2 = 64'($urandom_range(0, 3));
                default: s2 = {$urandom, $urandom};
            endcase
            tag = 4'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
        end
        rst = 1'b0; flush = 1'b0; vld = 1'b0; rdy = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < pe32.size(); i++) begin
            cmpCount++;
            if (po32[i] !== pe32[i]) begin
                failCount++; $display("FAIL sb32[%0d]: got %h want %h", i, po32[i], pe32[i]);
            end
        end
        for (int i = 0; i < pe64.size(); i++) begin
            cmpCount++;
            if (po64[i] !== pe64[i]) begin
                failCount++; $display("FAIL sb64[%0d]: got %h want %h", i, po64[i], pe64[i]);
            end
        end
        for (int i = 0; i < stA32.size(); i++) begin
            cmpCount++;
            if (stB32[i] !== stA32[i]) begin
                failCount++; $display("FAIL hold32[%0d]: got %h want %h", i, stB32[i], stA32[i]);
            end
        end
        for (int i = 0; i < stA64.size(); i++) begin
            cmpCount++;
            if (stB64[i] !== stA64[i]) begin
                failCount++; $display("FAIL hold64[%0d]: got %h want %h", i, stB64[i], stA64[i]);
            end
        end
        cmpCount++;
        if (unexp32 != 0 || unexp64 != 0 || expQ32.size() != 0 || expQ64.size() != 0) begin
            failCount++;
            $display("FAIL sb_balance: got extra %0d/%0d lost %0d/%0d want 0", unexp32, unexp64,
                     expQ32.size(), expQ64.size());
        end
        cmpCount++;
        if (pe32.size() < 100 || pe64.size() < 100 || stA32.size() < 20) begin
            failCount++;
            $display("FAIL sb_volume: got %0d/%0d results %0d holds want >=100/100/20",
                     pe32.size(), pe64.size(), stA32.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_compare();
        test_addw();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
